// File: rtl/freq_gate_ctrl_if.sv
// Control/result bundle between the frequency-counter sequencer and its user.
// Inputs run/trig/q come from the master side; the sequencer (slave) drives gate, latch and status.
interface freq_gate_ctrl_if #(
    parameter int unsigned WIDTH = 24
);
    logic             run;
    logic             trig;
    logic [WIDTH-1:0] q;
    logic             ena;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             busy;
    logic [2:0]       state;

    modport master (
        output run, trig, q,
        input  ena, clr, load, dout, valid, busy, state
    );

    modport slave (
        input  run, trig, q,
        output ena, clr, load, dout, valid, busy, state
    );
endinterface

// File: rtl/freq_gate_ctrl.sv
// Gate-window sequencer for a BCD frequency counter: clear, gate, settle, latch, hold.
// Latency: CLR_LEN+GATE_LEN+SETTLE_LEN+1+HOLD_LEN cycles per measurement; result valid on the first HOLD cycle.
// No backpressure: trig while busy is dropped, run is re-sampled only at the end of HOLD.
module freq_gate_ctrl #(
    parameter int unsigned GATE_LEN   = 16,
    parameter int unsigned CLR_LEN    = 2,
    parameter int unsigned HOLD_LEN   = 4,
    parameter int unsigned SETTLE_LEN = 2,
    parameter int unsigned WIDTH      = 24
) (
    input  logic           clk,
    input  logic           rst,
    freq_gate_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_GATE   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_LATCH  = 3'd4;
    localparam logic [2:0] S_HOLD   = 3'd5;

    localparam logic [15:0] CLR_LD    = 16'(CLR_LEN - 1);
    localparam logic [15:0] GATE_LD   = 16'(GATE_LEN - 1);
    localparam logic [15:0] SETTLE_LD = 16'(SETTLE_LEN - 1);
    localparam logic [15:0] HOLD_LD   = 16'(HOLD_LEN - 1);

    logic [2:0]       state;
    logic [15:0]      timer;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             timer_done;

    assign timer_done = (timer == 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            timer   <= 16'd0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= (state == S_LATCH);
            if (state == S_LATCH) begin
                dout_q <= bus.q;
            end
            case (state)
                S_IDLE: begin
                    if (bus.run || bus.trig) begin
                        state <= S_CLEAR;
                        timer <= CLR_LD;
                    end
                end
                S_CLEAR: begin
                    if (timer_done) begin
                        state <= S_GATE;
                        timer <= GATE_LD;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                S_GATE: begin
                    if (timer_done) begin
                        state <= S_SETTLE;
                        timer <= SETTLE_LD;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                S_SETTLE: begin
                    if (timer_done) begin
                        state <= S_LATCH;
                        timer <= 16'd0;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                S_LATCH: begin
                    state <= S_HOLD;
                    timer <= HOLD_LD;
                end
                S_HOLD: begin
                    // run is only looked at here, so a mid-measurement change takes effect after this result
                    if (timer_done) begin
                        if (bus.run) begin
                            state <= S_CLEAR;
                            timer <= CLR_LD;
                        end else begin
                            state <= S_IDLE;
                            timer <= 16'd0;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    timer <= 16'd0;
                end
            endcase
        end
    end

    assign bus.ena   = (state == S_GATE);
    assign bus.clr   = (state == S_IDLE) || (state == S_CLEAR);
    assign bus.load  = (state == S_LATCH);
    assign bus.busy  = (state != S_IDLE);
    assign bus.state = state;
    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;
endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl: a cycle-index reference model checked every cycle,
// plus hand-computed expectations per scenario.
module tb_freq_gate_ctrl;
    localparam int CL = 2;
    localparam int GL = 16;
    localparam int SL = 2;
    localparam int HL = 4;
    localparam int P  = CL + GL + SL + 1 + HL;
    localparam int K_SET = CL + GL;
    localparam int K_LAT = CL + GL + SL;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    bit   started;

    freq_gate_ctrl_if #(.WIDTH(24)) bus ();

    freq_gate_ctrl #(
        .GATE_LEN(GL), .CLR_LEN(CL), .HOLD_LEN(HL), .SETTLE_LEN(SL), .WIDTH(24)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Model: a measurement is just a position k in a P-cycle sequence.
    bit          m_busy;
    int          m_k;
    logic [23:0] m_dout;
    bit          m_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  = 0;
            m_k     = 0;
            m_dout  = 24'h0;
            m_valid = 0;
        end else begin
            m_valid = m_busy && (m_k == K_LAT);
            if (m_valid) m_dout = bus.q;
            if (!m_busy) begin
                if (bus.run || bus.trig) begin
                    m_busy = 1;
                    m_k    = 0;
                end
            end else if (m_k == P - 1) begin
                if (bus.run) m_k = 0;
                else m_busy = 0;
            end else begin
                m_k++;
            end
        end
    end

    function automatic logic [2:0] exp_state();
        if (!m_busy) return 3'd0;
        if (m_k < CL) return 3'd1;
        if (m_k < K_SET) return 3'd2;
        if (m_k < K_LAT) return 3'd3;
        if (m_k == K_LAT) return 3'd4;
        return 3'd5;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            chk("m_state", 32'(bus.state), 32'(exp_state()));
            chk("m_ena",   32'(bus.ena),   32'(m_busy && m_k >= CL && m_k < K_SET));
            chk("m_clr",   32'(bus.clr),   32'(!m_busy || m_k < CL));
            chk("m_load",  32'(bus.load),  32'(m_busy && m_k == K_LAT));
            chk("m_busy",  32'(bus.busy),  32'(m_busy));
            chk("m_valid", 32'(bus.valid), 32'(m_valid));
            chk("m_dout",  32'(bus.dout),  32'(m_dout));
        end
    end

    // Samples n cycles starting at the current negedge; optional trig pulses / run drop at given indices.
    task automatic watch(input int n, input int t1, input int t2, input int run_drop,
                         output int ena_c, output int valid_c, output int load_c,
                         output int clr_c, output int rises);
        logic prev_ena;
        prev_ena = bus.ena;
        ena_c = 0; valid_c = 0; load_c = 0; clr_c = 0; rises = 0;
        for (int i = 0; i < n; i++) begin
            ena_c   += int'(bus.ena);
            valid_c += int'(bus.valid);
            load_c  += int'(bus.load);
            clr_c   += int'(bus.clr);
            if (bus.ena && !prev_ena) rises++;
            prev_ena = bus.ena;
            bus.trig = (i == t1) || (i == t2);
            if (i == run_drop) bus.run = 1'b0;
            @(negedge clk);
        end
        bus.trig = 1'b0;
    endtask

    task automatic pulse_trig();
        @(negedge clk);
        bus.trig = 1'b1;
        @(negedge clk);
        bus.trig = 1'b0;
    endtask

    int e, v, l, c, r;

    initial begin
        n_chk = 0; n_fail = 0; started = 0;
        rst = 1'b0;
        bus.run = 1'b0; bus.trig = 1'b0; bus.q = 24'h0;
        #2 rst = 1'b1;
        #20;
        @(negedge clk);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_clr",   32'(bus.clr),   32'd1);
        chk("rst_ena",   32'(bus.ena),   32'd0);
        chk("rst_dout",  32'(bus.dout),  32'h0);
        rst = 1'b0;
        started = 1;
        @(negedge clk);

        // Single-shot with defaults
        bus.q = 24'h000123;
        pulse_trig();
        watch(P, -1, -1, -1, e, v, l, c, r);
        chk("ss_ena_cycles", 32'(e), 32'd16);
        chk("ss_clr_cycles", 32'(c), 32'd2);
        chk("ss_load",       32'(l), 32'd1);
        chk("ss_valid",      32'(v), 32'd1);
        chk("ss_idle_at_25", 32'(bus.state), 32'd0);
        chk("ss_dout",       32'(bus.dout), 32'h000123);

        // Continuous: 100 cycles, q steps per measurement window
        @(negedge clk);
        bus.run = 1'b1;
        v = 0; r = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            logic pe;
            pe = bus.ena;
            bus.q = 24'(((cyc / 25) + 1) * 16);
            v += int'(bus.valid);
            @(negedge clk);
            if (bus.ena && !pe) r++;
        end
        bus.run = 1'b0;
        chk("cont_valids", 32'(v), 32'd4);
        chk("cont_gates",  32'(r), 32'd4);
        chk("cont_dout",   32'(bus.dout), 32'h000040);
        @(negedge clk);
        chk("cont_idle", 32'(bus.state), 32'd0);

        // Trig while busy is ignored
        bus.q = 24'h000777;
        pulse_trig();
        watch(P, 4, 11, -1, e, v, l, c, r);
        chk("tb_ena_cycles", 32'(e), 32'd16);
        chk("tb_valid",      32'(v), 32'd1);
        chk("tb_gates",      32'(r), 32'd1);
        chk("tb_idle",       32'(bus.state), 32'd0);
        chk("tb_dout",       32'(bus.dout), 32'h000777);

        // Run dropped at gate cycle 5
        @(negedge clk);
        bus.run = 1'b1;
        bus.q = 24'h000555;
        @(negedge clk);
        watch(P, -1, -1, 6, e, v, l, c, r);
        chk("rd_ena_cycles", 32'(e), 32'd16);
        chk("rd_valid",      32'(v), 32'd1);
        chk("rd_idle",       32'(bus.state), 32'd0);
        watch(10, -1, -1, -1, e, v, l, c, r);
        chk("rd_no_regate",  32'(e + r), 32'd0);

        // Reset in gate cycle 8 after a prior result of 0x456
        bus.q = 24'h000456;
        pulse_trig();
        watch(P, -1, -1, -1, e, v, l, c, r);
        chk("pr_dout", 32'(bus.dout), 32'h000456);
        pulse_trig();
        watch(9, -1, -1, -1, e, v, l, c, r);
        chk("pr_in_gate", 32'(bus.ena), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_ena",   32'(bus.ena),   32'd0);
        chk("ar_clr",   32'(bus.clr),   32'd1);
        chk("ar_load",  32'(bus.load),  32'd0);
        chk("ar_valid", 32'(bus.valid), 32'd0);
        chk("ar_busy",  32'(bus.busy),  32'd0);
        chk("ar_dout",  32'(bus.dout),  32'h0);
        chk("ar_state", 32'(bus.state), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        watch(5, -1, -1, -1, e, v, l, c, r);
        chk("ar_no_valid", 32'(v + e), 32'd0);
        bus.q = 24'h000789;
        pulse_trig();
        watch(P, -1, -1, -1, e, v, l, c, r);
        chk("ar2_ena_cycles", 32'(e), 32'd16);
        chk("ar2_valid",      32'(v), 32'd1);
        chk("ar2_idle",       32'(bus.state), 32'd0);
        chk("ar2_dout",       32'(bus.dout), 32'h000789);

        @(negedge clk);
        started = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
